wb_arbiter_2m: RTL and testbench

- Two-master to one-slave pipelined Wishbone arbiter that shares the RAM port (memory wrapper, device 0) between the core instruction-fetch master (M0) and data load/store master (M1).
- Grants are round-robin and held for a whole bus cycle (i_mN_wb_cyc high).
- Tracks outstanding requests so acks return to the master that issued them.
- On abort (cyc dropped early), it drains stale acks before re-arbitrating.

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_outst_counter.sv | 46 ++++
 rtl/wb_arbiter_2m.sv | 162 ++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the two-master Wishbone arbiter
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

    localparam logic M_IFETCH = 1'b0;
    localparam logic M_DATA   = 1'b1;

endpackage

// File: rtl/wb_outst_counter.sv
// rtl/wb_outst_counter.sv - saturating up/down count of accepted-but-unacked requests
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_inc            request accepted by the slave this cycle
//   i_dec            ack returned by the slave this cycle
//   o_full           count == MAX_OUTST
//   o_empty          count == 0
//   o_count          current count
module wb_outst_counter #(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);

    logic [CNT_W-1:0] r_count;
    logic             w_inc_ok;
    logic             w_dec_ok;

    assign o_full   = (r_count == MAX_C);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;

    // An ack with nothing outstanding is stray and must not wrap the count.
    assign w_inc_ok = i_inc & ~o_full;
    assign w_dec_ok = i_dec & ~o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (w_inc_ok && !w_dec_ok) begin
            r_count <= r_count + 1'b1;
        end else if (!w_inc_ok && w_dec_ok) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - round-robin two-master to one-slave pipelined Wishbone arbiter
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_m0_wb_* / o_m0_wb_*       instruction-fetch master (cyc, stb, we, addr, data, sel / ack, stall, data)
//   i_m1_wb_* / o_m1_wb_*       data load/store master, same set
//   o_s_wb_* / i_s_wb_*         shared slave port (cyc, stb, we, addr, data, sel / ack, stall, data)
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_m0_wb_cyc,
    input  logic        i_m0_wb_stb,
    input  logic        i_m0_wb_we,
    input  logic [31:0] i_m0_wb_addr,
    input  logic [31:0] i_m0_wb_data,
    input  logic [3:0]  i_m0_wb_sel,
    output logic        o_m0_wb_ack,
    output logic        o_m0_wb_stall,
    output logic [31:0] o_m0_wb_data,

    input  logic        i_m1_wb_cyc,
    input  logic        i_m1_wb_stb,
    input  logic        i_m1_wb_we,
    input  logic [31:0] i_m1_wb_addr,
    input  logic [31:0] i_m1_wb_data,
    input  logic [3:0]  i_m1_wb_sel,
    output logic        o_m1_wb_ack,
    output logic        o_m1_wb_stall,
    output logic [31:0] o_m1_wb_data,

    output logic        o_s_wb_cyc,
    output logic        o_s_wb_stb,
    output logic        o_s_wb_we,
    output logic [31:0] o_s_wb_addr,
    output logic [31:0] o_s_wb_data,
    output logic [3:0]  o_s_wb_sel,
    input  logic        i_s_wb_ack,
    input  logic        i_s_wb_stall,
    input  logic [31:0] i_s_wb_data
);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic             r_last;
    logic             w_last_next;

    logic             w_inc;
    logic             w_dec;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;

    // Only requests the slave actually took count; acks are counted in any
    // state that may still have requests in flight, never in IDLE.
    assign w_inc = o_s_wb_stb & ~i_s_wb_stall;
    assign w_dec = i_s_wb_ack & (r_state != IDLE);

    wb_outst_counter #(
        .MAX_OUTST (MAX_OUTST),
        .CNT_W     (CNT_W)
    ) u_outst (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_inc),
        .i_dec   (w_dec),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_last  <= M_DATA;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        case (r_state)
            IDLE: begin
                if (i_m0_wb_cyc && i_m1_wb_cyc) begin
                    w_state_next = (r_last == M_IFETCH) ? GNT1 : GNT0;
                end else if (i_m0_wb_cyc) begin
                    w_state_next = GNT0;
                end else if (i_m1_wb_cyc) begin
                    w_state_next = GNT1;
                end
            end
            GNT0: begin
                if (!i_m0_wb_cyc) begin
                    w_last_next  = M_IFETCH;
                    w_state_next = w_empty ? IDLE : DRAIN;
                end
            end
            GNT1: begin
                if (!i_m1_wb_cyc) begin
                    w_last_next  = M_DATA;
                    w_state_next = w_empty ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                // Leave as soon as the final stale ack is seen, not a cycle later.
                if (w_empty || (w_count == CNT_W'(1) && i_s_wb_ack)) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_s_wb_cyc    = 1'b0;
        o_s_wb_stb    = 1'b0;
        o_s_wb_we     = 1'b0;
        o_s_wb_addr   = '0;
        o_s_wb_data   = '0;
        o_s_wb_sel    = '0;
        o_m0_wb_ack   = 1'b0;
        o_m0_wb_stall = 1'b1;
        o_m0_wb_data  = '0;
        o_m1_wb_ack   = 1'b0;
        o_m1_wb_stall = 1'b1;
        o_m1_wb_data  = '0;
        case (r_state)
            GNT0: begin
                o_s_wb_cyc    = i_m0_wb_cyc;
                o_s_wb_stb    = i_m0_wb_cyc & i_m0_wb_stb & ~w_full;
                o_s_wb_we     = i_m0_wb_we;
                o_s_wb_addr   = i_m0_wb_addr;
                o_s_wb_data   = i_m0_wb_data;
                o_s_wb_sel    = i_m0_wb_sel;
                o_m0_wb_stall = i_s_wb_stall | w_full;
                o_m0_wb_ack   = i_s_wb_ack;
                o_m0_wb_data  = i_s_wb_data;
            end
            GNT1: begin
                o_s_wb_cyc    = i_m1_wb_cyc;
                o_s_wb_stb    = i_m1_wb_cyc & i_m1_wb_stb & ~w_full;
                o_s_wb_we     = i_m1_wb_we;
                o_s_wb_addr   = i_m1_wb_addr;
                o_s_wb_data   = i_m1_wb_data;
                o_s_wb_sel    = i_m1_wb_sel;
                o_m1_wb_stall = i_s_wb_stall | w_full;
                o_m1_wb_ack   = i_s_wb_ack;
                o_m1_wb_data  = i_s_wb_data;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - directed self-checking bench for wb_arbiter_2m
module tb_wb_arbiter_2m;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_m0_wb_cyc, i_m0_wb_stb, i_m0_wb_we;
    logic [31:0] i_m0_wb_addr, i_m0_wb_data;
    logic [3:0]  i_m0_wb_sel;
    logic        o_m0_wb_ack, o_m0_wb_stall;
    logic [31:0] o_m0_wb_data;
    logic        i_m1_wb_cyc, i_m1_wb_stb, i_m1_wb_we;
    logic [31:0] i_m1_wb_addr, i_m1_wb_data;
    logic [3:0]  i_m1_wb_sel;
    logic        o_m1_wb_ack, o_m1_wb_stall;
    logic [31:0] o_m1_wb_data;
    logic        o_s_wb_cyc, o_s_wb_stb, o_s_wb_we;
    logic [31:0] o_s_wb_addr, o_s_wb_data;
    logic [3:0]  o_s_wb_sel;
    logic        i_s_wb_ack, i_s_wb_stall;
    logic [31:0] i_s_wb_data;

    int n_cmp = 0;
    int n_err = 0;

    wb_arbiter_2m #(.MAX_OUTST(4), .CNT_W(4)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_m0_wb_cyc   (i_m0_wb_cyc),
        .i_m0_wb_stb   (i_m0_wb_stb),
        .i_m0_wb_we    (i_m0_wb_we),
        .i_m0_wb_addr  (i_m0_wb_addr),
        .i_m0_wb_data  (i_m0_wb_data),
        .i_m0_wb_sel   (i_m0_wb_sel),
        .o_m0_wb_ack   (o_m0_wb_ack),
        .o_m0_wb_stall (o_m0_wb_stall),
        .o_m0_wb_data  (o_m0_wb_data),
        .i_m1_wb_cyc   (i_m1_wb_cyc),
        .i_m1_wb_stb   (i_m1_wb_stb),
        .i_m1_wb_we    (i_m1_wb_we),
        .i_m1_wb_addr  (i_m1_wb_addr),
        .i_m1_wb_data  (i_m1_wb_data),
        .i_m1_wb_sel   (i_m1_wb_sel),
        .o_m1_wb_ack   (o_m1_wb_ack),
        .o_m1_wb_stall (o_m1_wb_stall),
        .o_m1_wb_data  (o_m1_wb_data),
        .o_s_wb_cyc    (o_s_wb_cyc),
        .o_s_wb_stb    (o_s_wb_stb),
        .o_s_wb_we     (o_s_wb_we),
        .o_s_wb_addr   (o_s_wb_addr),
        .o_s_wb_data   (o_s_wb_data),
        .o_s_wb_sel    (o_s_wb_sel),
        .i_s_wb_ack    (i_s_wb_ack),
        .i_s_wb_stall  (i_s_wb_stall),
        .i_s_wb_data   (i_s_wb_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_m0_wb_cyc = 0; i_m0_wb_stb = 0; i_m0_wb_we = 0;
        i_m0_wb_addr = 0; i_m0_wb_data = 0; i_m0_wb_sel = 0;
        i_m1_wb_cyc = 0; i_m1_wb_stb = 0; i_m1_wb_we = 0;
        i_m1_wb_addr = 0; i_m1_wb_data = 0; i_m1_wb_sel = 0;
        i_s_wb_ack = 0; i_s_wb_stall = 0; i_s_wb_data = 0;
    endtask

    task automatic reset_dut();
        i_rst_n = 0;
        clear_inputs();
        tick();
        tick();
        i_rst_n = 1;
    endtask

    int          issued, acked, got_acks, exp_outst;
    logic        gnt, exp_acc, ack_exp, saw_full;
    logic [3:0]  pipe;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_rst_n = 0;
        clear_inputs();
        reset_dut();

        // Reset state
        #1;
        chk("rst_s_cyc",    o_s_wb_cyc, 0);
        chk("rst_s_stb",    o_s_wb_stb, 0);
        chk("rst_s_addr",   o_s_wb_addr, 0);
        chk("rst_m0_stall", o_m0_wb_stall, 1);
        chk("rst_m1_stall", o_m1_wb_stall, 1);
        chk("rst_m0_ack",   o_m0_wb_ack, 0);
        chk("rst_m1_data",  o_m1_wb_data, 0);

        // Single M0 read, slave acks the next cycle
        i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m0_wb_addr = 32'h100; i_m0_wb_sel = 4'hF;
        #1;
        chk("t1_req_m0_stall", o_m0_wb_stall, 1);
        chk("t1_req_s_cyc",    o_s_wb_cyc, 0);
        tick();
        #1;
        chk("t1_gnt_s_cyc",    o_s_wb_cyc, 1);
        chk("t1_gnt_s_stb",    o_s_wb_stb, 1);
        chk("t1_gnt_s_addr",   o_s_wb_addr, 32'h100);
        chk("t1_gnt_s_sel",    o_s_wb_sel, 4'hF);
        chk("t1_gnt_m0_stall", o_m0_wb_stall, 0);
        chk("t1_gnt_m1_stall", o_m1_wb_stall, 1);
        tick();
        i_m0_wb_stb = 0; i_s_wb_ack = 1; i_s_wb_data = 32'hDEADBEEF;
        #1;
        chk("t1_m0_ack",      o_m0_wb_ack, 1);
        chk("t1_m0_data",     o_m0_wb_data, 32'hDEADBEEF);
        chk("t1_m1_ack",      o_m1_wb_ack, 0);
        chk("t1_m1_data",     o_m1_wb_data, 0);
        chk("t1_ack_m1_stall", o_m1_wb_stall, 1);
        chk("t1_ack_s_stb",   o_s_wb_stb, 0);
        tick();
        chk("t1_cnt_after_ack", dut.u_outst.o_count, 0);
        i_m0_wb_cyc = 0; i_s_wb_ack = 0;
        #1;
        chk("t1_drop_s_cyc", o_s_wb_cyc, 0);
        tick();
        #1;
        chk("t1_idle_m0_stall", o_m0_wb_stall, 1);

        // Round-robin alternation after reset
        reset_dut();
        i_m0_wb_cyc = 1; i_m0_wb_addr = 32'hA0;
        i_m1_wb_cyc = 1; i_m1_wb_addr = 32'hB0;
        tick();
        #1;
        chk("t2_first_s_addr",   o_s_wb_addr, 32'hA0);
        chk("t2_first_m0_stall", o_m0_wb_stall, 0);
        chk("t2_first_m1_stall", o_m1_wb_stall, 1);
        i_m0_wb_cyc = 0;
        tick();
        #1;
        chk("t2_gap_s_cyc",    o_s_wb_cyc, 0);
        chk("t2_gap_m1_stall", o_m1_wb_stall, 1);
        tick();
        #1;
        chk("t2_second_s_addr",   o_s_wb_addr, 32'hB0);
        chk("t2_second_s_cyc",    o_s_wb_cyc, 1);
        chk("t2_second_m1_stall", o_m1_wb_stall, 0);
        i_m1_wb_cyc = 0;
        tick();
        i_m0_wb_cyc = 1; i_m1_wb_cyc = 1;
        tick();
        #1;
        chk("t2_third_s_addr",   o_s_wb_addr, 32'hA0);
        chk("t2_third_m1_stall", o_m1_wb_stall, 1);
        i_m0_wb_cyc = 0; i_m1_wb_cyc = 0;
        tick();

        // M1 burst of 6 against a slave that acks 4 cycles after accepting
        reset_dut();
        i_m1_wb_cyc = 1; i_m1_wb_we = 1; i_m1_wb_sel = 4'hF;
        issued = 0; acked = 0; got_acks = 0; exp_outst = 0;
        gnt = 0; pipe = 4'b0; saw_full = 0;
        for (int c = 0; c < 30 && acked < 6; c++) begin
            i_m1_wb_stb  = (issued < 6);
            i_m1_wb_addr = 32'h200 + 32'(issued * 4);
            i_m1_wb_data = 32'h1000 + 32'(issued);
            ack_exp      = pipe[3];
            i_s_wb_ack   = ack_exp;
            i_s_wb_data  = 32'hA000 + 32'(acked);
            #1;
            exp_acc = gnt && i_m1_wb_stb && (exp_outst != 4);
            chk("t3_m0_stall", o_m0_wb_stall, 1);
            if (gnt) begin
                chk("t3_m1_stall", o_m1_wb_stall, (exp_outst == 4));
                chk("t3_s_stb",    o_s_wb_stb, exp_acc);
                chk("t3_m1_ack",   o_m1_wb_ack, ack_exp);
                if (exp_outst == 4) saw_full = 1;
            end else begin
                chk("t3_idle_m1_stall", o_m1_wb_stall, 1);
            end
            if (o_m1_wb_ack) got_acks++;
            if (exp_acc) begin
                issued++;
                exp_outst++;
            end
            if (ack_exp) begin
                acked++;
                if (exp_outst > 0) exp_outst--;
            end
            pipe = {pipe[2:0], exp_acc};
            tick();
            gnt = 1;
        end
        chk("t3_saw_full", saw_full, 1);
        chk("t3_issued",   issued, 6);
        chk("t3_m1_acks",  got_acks, 6);
        chk("t3_cnt_end",  dut.u_outst.o_count, 0);
        i_s_wb_ack = 0; i_m1_wb_cyc = 0; i_m1_wb_stb = 0;
        tick();
        tick();

        // M0 aborts with two requests in flight; M1 waits for the drain
        reset_dut();
        i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m0_wb_addr = 32'h40;
        i_m1_wb_cyc = 1; i_m1_wb_addr = 32'h80;
        tick();
        tick();
        tick();
        chk("t4_cnt_two", dut.u_outst.o_count, 2);
        i_m0_wb_cyc = 0; i_m0_wb_stb = 0;
        #1;
        chk("t4_abort_s_cyc", o_s_wb_cyc, 0);
        tick();
        for (int k = 0; k < 2; k++) begin
            i_s_wb_ack = 1; i_s_wb_data = 32'h5555_0000 + 32'(k);
            #1;
            chk("t4_drain_m0_ack",   o_m0_wb_ack, 0);
            chk("t4_drain_m1_ack",   o_m1_wb_ack, 0);
            chk("t4_drain_s_cyc",    o_s_wb_cyc, 0);
            chk("t4_drain_m1_stall", o_m1_wb_stall, 1);
            chk("t4_drain_m0_data",  o_m0_wb_data, 0);
            tick();
        end
        i_s_wb_ack = 0;
        #1;
        chk("t4_idle_s_cyc",    o_s_wb_cyc, 0);
        chk("t4_idle_m1_stall", o_m1_wb_stall, 1);
        tick();
        #1;
        chk("t4_m1_gnt_stall", o_m1_wb_stall, 0);
        chk("t4_m1_gnt_addr",  o_s_wb_addr, 32'h80);
        i_m1_wb_cyc = 0;
        tick();

        // Asynchronous reset while M1 owns the bus with two outstanding
        reset_dut();
        i_m1_wb_cyc = 1; i_m1_wb_stb = 1; i_m1_wb_addr = 32'h300;
        tick();
        tick();
        tick();
        i_m1_wb_stb = 0;
        #1;
        chk("t5_pre_cnt",   dut.u_outst.o_count, 2);
        chk("t5_pre_s_cyc", o_s_wb_cyc, 1);
        i_rst_n = 0; i_m1_wb_cyc = 0;
        #1;
        chk("t5_rst_s_cyc",    o_s_wb_cyc, 0);
        chk("t5_rst_s_addr",   o_s_wb_addr, 0);
        chk("t5_rst_m1_stall", o_m1_wb_stall, 1);
        chk("t5_rst_cnt",      dut.u_outst.o_count, 0);
        tick();
        i_rst_n = 1;
        i_s_wb_ack = 1; i_s_wb_data = 32'h1234_5678;
        #1;
        chk("t5_stray_m1_ack", o_m1_wb_ack, 0);
        chk("t5_stray_m0_ack", o_m0_wb_ack, 0);
        tick();
        i_s_wb_ack = 0;
        chk("t5_stray_cnt", dut.u_outst.o_count, 0);

        // Slave stalls three cycles during an M0 grant
        reset_dut();
        i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m0_wb_addr = 32'h400;
        tick();
        for (int k = 0; k < 3; k++) begin
            i_s_wb_stall = 1;
            #1;
            chk("t6_stall_m0",  o_m0_wb_stall, 1);
            chk("t6_stall_stb", o_s_wb_stb, 1);
            chk("t6_stall_cnt", dut.u_outst.o_count, 0);
            tick();
        end
        i_s_wb_stall = 0;
        #1;
        chk("t6_accept_m0_stall", o_m0_wb_stall, 0);
        tick();
        chk("t6_accept_cnt", dut.u_outst.o_count, 1);
        i_m0_wb_stb = 0; i_s_wb_ack = 1; i_s_wb_data = 32'hCAFE_F00D;
        #1;
        chk("t6_ack",      o_m0_wb_ack, 1);
        chk("t6_ack_data", o_m0_wb_data, 32'hCAFE_F00D);
        tick();
        chk("t6_ack_cnt", dut.u_outst.o_count, 0);
        i_s_wb_ack = 0; i_m0_wb_cyc = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
